// File: rtl/if_stage_if.sv
// Bus bundle between the instruction-fetch stage and its environment.
// The environment side (ID stage, hazard unit, instruction memory) uses the
// master modport; the fetch stage uses the slave modport.
interface if_stage_if;
  logic [2:0]  PCSrc;
  logic [31:0] BranchAddr;
  logic [31:0] JumpAddr;
  logic [31:0] JrAddr;
  logic        Stall;
  logic [31:0] Inst;
  logic [31:0] InstAddr;
  logic [31:0] PCAdd4;
  logic [31:0] ID_Inst;
  logic [31:0] ID_PCAdd4;
  logic        ID_Valid;
  logic        AddrErr;

  modport master (
    output PCSrc, BranchAddr, JumpAddr, JrAddr, Stall, Inst,
    input  InstAddr, PCAdd4, ID_Inst, ID_PCAdd4, ID_Valid, AddrErr
  );

  modport slave (
    input  PCSrc, BranchAddr, JumpAddr, JrAddr, Stall, Inst,
    output InstAddr, PCAdd4, ID_Inst, ID_PCAdd4, ID_Valid, AddrErr
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage of a 5-stage MIPS pipeline.
// Holds the PC, forms PC+4, selects the next PC from ID-supplied targets and
// registers the fetched instruction into the IF/ID pipeline register.
// Optional feature macro: IF_DELAY_SLOT_EN -- when defined, the instruction
// fetched in a redirect cycle is kept (branch delay slot); otherwise it is
// squashed to NOP_INST with ID_Valid=0.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input logic        Clk,
  input logic        Clrn,
  if_stage_if.slave  bus
);

`ifdef IF_DELAY_SLOT_EN
  localparam bit SQUASH_ON_REDIRECT = 1'b0;
`else
  localparam bit SQUASH_ON_REDIRECT = 1'b1;
`endif

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_add4_q, id_pc_add4_d;
  logic        id_valid_q, id_valid_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] pc_add4;
  logic [31:0] target;
  logic        squash;

  // Sequential PC+4; 32-bit modulo arithmetic, wrap is silent.
  assign pc_add4 = pc_q + 32'd4;

  // Next-PC target selection from the PCSrc encoding (110/111 fall back to PC+4).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path can leave it unassigned and infer a latch.
    target = pc_add4;
    squash = 1'b0;
    case (bus.PCSrc)
      3'b001: begin
        target = bus.BranchAddr;
        squash = SQUASH_ON_REDIRECT;
      end
      3'b010, 3'b011: begin
        target = bus.JumpAddr;
        squash = SQUASH_ON_REDIRECT;
      end
      3'b100, 3'b101: begin
        target = bus.JrAddr;
        squash = SQUASH_ON_REDIRECT;
      end
      default: ;
    endcase
  end

  // Next-state for PC, IF/ID and the sticky alignment error; Stall freezes all.
  always_comb begin
    pc_d         = pc_q;
    id_inst_d    = id_inst_q;
    id_pc_add4_d = id_pc_add4_q;
    id_valid_d   = id_valid_q;
    addr_err_d   = addr_err_q;
    if (!bus.Stall) begin
      pc_d         = {target[31:2], 2'b00};
      addr_err_d   = addr_err_q | (|target[1:0]);
      id_pc_add4_d = pc_add4;
      id_inst_d    = squash ? NOP_INST : bus.Inst;
      id_valid_d   = ~squash;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Clrn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!Clrn) begin
      pc_q         <= RESET_PC;
      id_inst_q    <= NOP_INST;
      id_pc_add4_q <= 32'h0000_0000;
      id_valid_q   <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      id_inst_q    <= id_inst_d;
      id_pc_add4_q <= id_pc_add4_d;
      id_valid_q   <= id_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign bus.InstAddr  = pc_q;
  assign bus.PCAdd4    = pc_add4;
  assign bus.ID_Inst   = id_inst_q;
  assign bus.ID_PCAdd4 = id_pc_add4_q;
  assign bus.ID_Valid  = id_valid_q;
  assign bus.AddrErr   = addr_err_q;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: holds the program counter, forms PC+4, selects the next PC from the branch/jump/jr targets produced downstream in ID, and registers the fetched instruction into the IF/ID pipeline register. It drives the instruction-memory address and feeds the ID stage, where the PC-source and forwarding multiplexers consume its outputs. Stall, redirect-flush and an optional branch delay slot are handled here.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID on flush/reset.
- Clk  in  1  rising-edge clock.
- Clrn  in  1  asynchronous, active-low reset.
- PCSrc  in  3  next-PC select from ID: 000 PC+4; 001 BranchAddr; 010/011 JumpAddr; 100/101 JrAddr; 110/111 reserved, treated as 000.
- BranchAddr  in  32  branch target from ID.
- JumpAddr  in  32  jump target from ID.
- JrAddr  in  32  register jump target from ID.
- Stall  in  1  hazard-unit stall: hold PC and IF/ID.
- Inst  in  32  instruction-memory read data for InstAddr (combinational, same cycle).
- InstAddr  out  32  current PC to instruction memory.
- PCAdd4  out  32  InstAddr + 4 (combinational).
- ID_Inst  out  32  registered instruction for ID.
- ID_PCAdd4  out  32  registered PC+4 for ID.
- ID_Valid  out  1  ID_Inst is a real instruction (0 = bubble).
- AddrErr  out  1  sticky: a non-word-aligned target was selected.

## Operation
- NextPC chosen per PCSrc encoding; redirect = PCSrc in {001,010,011,100,101}.
- NextPC[1:0] forced to 2'b00; if selected target had nonzero [1:0], AddrErr sets on that edge and stays 1 until reset.
- PC register: on each edge with Stall=0, PC <= NextPC; Stall=1 holds PC.
- IF/ID register, Stall=0: if redirect and delay slot disabled, load NOP_INST, PCAdd4 of squashed fetch kept in ID_PCAdd4, ID_Valid=0; otherwise load Inst, PCAdd4, ID_Valid=1.
- Stall=1: IF/ID holds all fields including ID_Valid; redirect ignored that cycle (ID re-presents PCSrc next cycle since it is also held). Stall has priority over redirect.
- PCAdd4 arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0, no flag.
- AddrErr is not cleared by Stall or redirect.

## Timing
- Reset (Clrn low, asynchronous): InstAddr=RESET_PC, ID_Inst=NOP_INST, ID_PCAdd4=0, ID_Valid=0, AddrErr=0. Holds while Clrn low regardless of Clk.
- First rising edge after Clrn deasserts: IF/ID captures Inst at RESET_PC, ID_Valid=1; PC=RESET_PC+4.
- Fetch-to-ID latency: 1 cycle. Redirect penalty: 1 bubble (delay slot off) or 0 (on).
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately; no partial update.
- Stall held N cycles: InstAddr and IF/ID outputs constant for N cycles; resume on first edge with Stall=0.

## Configuration
- IF_DELAY_SLOT_EN defined: instruction fetched in the cycle a redirect is presented is kept (ID_Valid=1); MIPS branch delay-slot semantics.
- Not defined: that instruction is squashed to NOP_INST with ID_Valid=0.
- NextPC, Stall and AddrErr behaviour identical in both builds.

## Test plan
- Reset then run with PCSrc=000, Stall=0, Inst=addr-derived pattern -> InstAddr steps 0,4,8,C; ID_PCAdd4 = 4,8,C,10 one cycle later; ID_Valid=1 from first edge.
- At PC=0x10 present PCSrc=001, BranchAddr=0x40 -> next InstAddr=0x40; ID_Inst=NOP, ID_Valid=0 (macro off) or Inst@0x10, ID_Valid=1 (macro on); next cycle ID holds Inst@0x40.
- PCSrc=100 with JrAddr=0x102 -> InstAddr=0x100, AddrErr=1 and stays 1 through further redirects until Clrn low.
- Stall=1 for 3 cycles with PCSrc=010, JumpAddr=0x80 -> InstAddr and IF/ID unchanged 3 cycles; after Stall drops, jump taken, InstAddr=0x80.
- Clrn pulsed low between edges at PC=0x24 -> InstAddr=RESET_PC immediately, ID_Valid=0, ID_Inst=NOP_INST before the next edge.
- PC=0xFFFF_FFFC, PCSrc=000 -> PCAdd4=0, next InstAddr=0, AddrErr remains 0.
